hbc_mcp_sequencer: RTL

HBC_MCP_SEQUENCER -- requirements
Module: hbc_mcp_sequencer

---
 rtl/hbc_mcp_pkg.sv | 56 +++++
 rtl/hbc_mcp_mul_seq.sv | 59 +++++
 rtl/hbc_mcp_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hbc_mcp_pkg.sv
// hbc_mcp_pkg -- shared constants and types for the host-bus multiply
// coprocessor sequencer.
//   * register address map (write and read sides)
//   * CMD / STATUS bit positions
//   * iteration count of the shift-add multiplier
//   * sequencer FSM state type
//   * operand magnitude helper used by the datapath
package hbc_mcp_pkg;

   // Write-side address map
   localparam logic [2:0] ADDR_AH     = 3'd0;
   localparam logic [2:0] ADDR_AL     = 3'd1;
   localparam logic [2:0] ADDR_BH     = 3'd2;
   localparam logic [2:0] ADDR_BL     = 3'd3;
   localparam logic [2:0] ADDR_CMD    = 3'd4;

   // Read-side address map (result bytes MSB first)
   localparam logic [2:0] ADDR_R3     = 3'd0;
   localparam logic [2:0] ADDR_R2     = 3'd1;
   localparam logic [2:0] ADDR_R1     = 3'd2;
   localparam logic [2:0] ADDR_R0     = 3'd3;
   localparam logic [2:0] ADDR_STATUS = 3'd4;
   localparam logic [2:0] ADDR_ID     = 3'd5;

   // CMD register bits
   localparam int CMD_START  = 0;
   localparam int CMD_SIGNED = 1;
   localparam int CMD_CLR    = 7;

   // STATUS register bits
   localparam int STAT_BUSY = 7;
   localparam int STAT_DONE = 6;
   localparam int STAT_OVR  = 5;

   // One shift-add step per operand bit
   localparam int MUL_STEPS  = 16;
   localparam int STEP_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_FIX  = 2'd3
   } seq_state_t;

   // Magnitude of a 16-bit operand. For signed mode -32768 maps to
   // 16'h8000, which is still the correct unsigned magnitude.
   function automatic logic [15:0] op_magnitude(input logic [15:0] v,
                                                input logic        is_signed);
      if (is_signed && v[15]) begin
         return (~v) + 16'd1;
      end
      return v;
   endfunction

endpackage

// File: rtl/hbc_mcp_mul_seq.sv
// hbc_mcp_mul_seq -- iterative 16x16 shift-add multiplier.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : snapshot op_a/op_b/is_signed, convert to magnitudes
//   step        : perform one shift-add step on the 32-bit accumulator
//   fix         : apply the recorded sign and write all 32 product bits
//   op_a, op_b  : 16-bit operands
//   is_signed   : 1 = two's complement operands, 0 = unsigned
//   product     : registered 32-bit product, changes only on fix/reset
module hbc_mcp_mul_seq
   import hbc_mcp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic        fix,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   input  logic        is_signed,
   output logic [31:0] product
);

   logic [15:0] mcand_q;
   logic [31:0] acc_q;
   logic        neg_q;
   logic [31:0] product_q;
   logic [16:0] sum;

   // Upper half of acc holds the partial product, lower half the
   // not-yet-consumed multiplier bits. The 17-bit sum keeps the carry,
   // which drops into bit 31 as the accumulator shifts right.
   always_comb begin
      sum = {1'b0, acc_q[31:16]} + (acc_q[0] ? {1'b0, mcand_q} : 17'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_q   <= 16'd0;
         acc_q     <= 32'd0;
         neg_q     <= 1'b0;
         product_q <= 32'd0;
      end else begin
         if (load) begin
            mcand_q <= op_magnitude(op_a, is_signed);
            acc_q   <= {16'd0, op_magnitude(op_b, is_signed)};
            neg_q   <= is_signed & (op_a[15] ^ op_b[15]);
         end else if (step) begin
            acc_q <= {sum, acc_q[15:1]};
         end
         if (fix) begin
            product_q <= neg_q ? ((~acc_q) + 32'd1) : acc_q;
         end
      end
   end

   assign product = product_q;

endmodule

// File: rtl/hbc_mcp_sequencer.sv
// hbc_mcp_sequencer -- host-bus register front end and control FSM for the
// 16x16 multiply coprocessor.
// Ports:
//   clk      : 27 MHz system clock
//   rst_n    : synchronous active-low reset
//   wr_n     : asynchronous host write strobe (active low)
//   rd_n     : asynchronous host read strobe (active low)
//   address  : host register address
//   data_in  : host write data
//   data_out : host read data (combinational mux on raw address)
//   data_oe  : tri-state enable for data_out at the pad level
//   irq      : level copy of STATUS.DONE
// Handshake: a write is committed on the synchronised rising edge of wr_n,
// using the last address/data pair captured while synchronised wr_n was low.
// Reads need no synchronisation: data_out is a mux of registered state.
module hbc_mcp_sequencer
   import hbc_mcp_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,     // must be >= 2
   parameter logic [7:0] ID_VALUE    = 8'hA5
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_n,
   input  logic       rd_n,
   input  logic [2:0] address,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       irq
);

   // Host write synchroniser and commit detection
   logic [SYNC_STAGES-1:0] wr_sync_q;
   logic                   wr_s;
   logic                   wr_prev_q;
   logic [2:0]             addr_q;
   logic [7:0]             wdata_q;
   logic                   commit;

   assign wr_s   = wr_sync_q[SYNC_STAGES-1];
   // Sync flops and wr_prev reset high, so a strobe held across reset
   // release only commits after its synced falling edge is seen.
   assign commit = ~wr_prev_q & wr_s;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_sync_q <= '1;
         wr_prev_q <= 1'b1;
         addr_q    <= 3'd0;
         wdata_q   <= 8'd0;
      end else begin
         wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], wr_n};
         wr_prev_q <= wr_s;
         if (!wr_s) begin
            addr_q  <= address;
            wdata_q <= data_in;
         end
      end
   end

   // Command decode
   seq_state_t state_q, state_d;
   logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
   logic busy;
   logic cmd_wr, start_req, clr_req, start_go;

   assign busy      = (state_q != ST_IDLE);
   assign cmd_wr    = commit && (addr_q == ADDR_CMD);
   assign start_req = cmd_wr & wdata_q[CMD_START];
   assign clr_req   = cmd_wr & wdata_q[CMD_CLR];
   assign start_go  = start_req & ~busy;

   // Register file and status
   logic [15:0] a_q, b_q;
   logic        signed_q;
   logic        done_q, ovr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q      <= 16'd0;
         b_q      <= 16'd0;
         signed_q <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         if (commit) begin
            case (addr_q)
               ADDR_AH: a_q[15:8] <= wdata_q;
               ADDR_AL: a_q[7:0]  <= wdata_q;
               ADDR_BH: b_q[15:8] <= wdata_q;
               ADDR_BL: b_q[7:0]  <= wdata_q;
               default: ;
            endcase
         end
         // CLR is applied before START so CLR+START clears then starts.
         if (clr_req) begin
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
         end
         if (start_req) begin
            if (busy) begin
               ovr_q <= 1'b1;
            end else begin
               done_q   <= 1'b0;
               signed_q <= wdata_q[CMD_SIGNED];
            end
         end
         if (state_q == ST_FIX) begin
            done_q <= 1'b1;
         end
      end
   end

   // Sequencer FSM: IDLE -> LOAD (1) -> RUN (MUL_STEPS) -> FIX (1) -> IDLE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start_go) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == STEP_CNT_W'(MUL_STEPS - 1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath
   logic [31:0] result;

   hbc_mcp_mul_seq u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (state_q == ST_LOAD),
      .step      (state_q == ST_RUN),
      .fix       (state_q == ST_FIX),
      .op_a      (a_q),
      .op_b      (b_q),
      .is_signed (signed_q),
      .product   (result)
   );

   // Host read side
   logic [7:0] status;

   always_comb begin
      status            = 8'h00;
      status[STAT_BUSY] = busy;
      status[STAT_DONE] = done_q;
      status[STAT_OVR]  = ovr_q;
   end

   always_comb begin
      data_out = 8'h00;
      case (address)
         ADDR_R3:     data_out = result[31:24];
         ADDR_R2:     data_out = result[23:16];
         ADDR_R1:     data_out = result[15:8];
         ADDR_R0:     data_out = result[7:0];
         ADDR_STATUS: data_out = status;
         ADDR_ID:     data_out = ID_VALUE;
         default:     data_out = 8'h00;
      endcase
   end

   // A write always wins the shared data pins.
   assign data_oe = ~rd_n & wr_n;
   assign irq     = done_q;

endmodule
